// File: rtl/s011hd1p_arbiter.sv
// Single-port 64x20 SRAM access controller: power-on clear, then
// round-robin write/read arbitration with a held read response.
module s011hd1p_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 20,
  parameter int DEPTH  = 64
) (
  input  logic              CLK,
  input  logic              RSTN,
  output logic              init_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef enum logic [1:0] {
    BOOT,
    INIT,
    RUN
  } state_e;

  typedef enum logic {
    PRIO_WR,
    PRIO_RD
  } prio_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  prio_e             prio_q, prio_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;
  logic              resp_pending_q, resp_pending_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              wr_gnt;
  logic              rd_gnt;

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (state_q == RUN) begin
      unique case (1'b1)
        wr_valid && rd_valid: begin
          wr_gnt = (prio_q == PRIO_WR);
          rd_gnt = (prio_q == PRIO_RD);
        end
        wr_valid && !rd_valid: wr_gnt = 1'b1;
        !wr_valid && rd_valid: rd_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  // Macro pins follow the grant combinationally; the macro
  // samples them at the edge that closes the handshake.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    case (state_q)
      BOOT: begin
        state_d   = INIT;
        clr_cnt_d = '0;
      end
      INIT: begin
        sram_ceb  = 1'b0;
        sram_web  = 1'b0;
        sram_a    = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr_gnt) begin
          sram_ceb = 1'b0;
          sram_web = 1'b0;
          sram_a   = wr_addr;
          sram_d   = wr_data;
        end else if (rd_gnt) begin
          sram_ceb = 1'b0;
          sram_a   = rd_addr;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (wr_gnt) begin
      prio_d = PRIO_RD;
    end else if (rd_gnt) begin
      prio_d = PRIO_WR;
    end
  end

  assign init_done_d    = (state_d == RUN);
  assign resp_pending_d = rd_gnt;
  // Q is only defined in the cycle after a read; keep a copy.
  assign hold_d = resp_pending_q ? sram_q : hold_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q        <= BOOT;
      prio_q         <= PRIO_WR;
      clr_cnt_q      <= '0;
      init_done_q    <= 1'b0;
      resp_pending_q <= 1'b0;
      hold_q         <= '0;
    end else begin
      state_q        <= state_d;
      prio_q         <= prio_d;
      clr_cnt_q      <= clr_cnt_d;
      init_done_q    <= init_done_d;
      resp_pending_q <= resp_pending_d;
      hold_q         <= hold_d;
    end
  end

  assign init_done     = init_done_q;
  assign wr_ready      = wr_gnt;
  assign rd_ready      = rd_gnt;
  assign rd_resp_valid = resp_pending_q;
  assign rd_resp_data  = resp_pending_q ? sram_q : hold_q;

endmodule

// File: tb/tb_s011hd1p_arbiter.sv
// Scoreboard bench for s011hd1p_arbiter with a behavioural
// registered-Q SRAM that drives junk on non-read cycles.
module tb_s011hd1p_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        init_done;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_addr = '0;
  logic [19:0] wr_data = '0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [5:0]  rd_addr = '0;
  logic        rd_resp_valid;
  logic [19:0] rd_resp_data;
  logic        sram_ceb;
  logic        sram_web;
  logic [5:0]  sram_a;
  logic [19:0] sram_d;
  logic [19:0] sram_q;

  s011hd1p_arbiter dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .init_done    (init_done),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .sram_ceb     (sram_ceb),
    .sram_web     (sram_web),
    .sram_a       (sram_a),
    .sram_d       (sram_d),
    .sram_q       (sram_q)
  );

  always #5 CLK = ~CLK;

  // SRAM model: starts with nonzero junk so the clear is visible.
  logic [19:0] mem [64];
  logic [19:0] q_r = '0;
  logic        seeded = 1'b0;
  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 20'hD0000 | 20'(i);
      seeded <= 1'b1;
      q_r    <= 20'($urandom);
    end else if (!sram_ceb && sram_web) begin
      q_r <= mem[sram_a];
    end else begin
      if (!sram_ceb) mem[sram_a] <= sram_d;
      q_r <= 20'($urandom);
    end
  end
  assign sram_q = q_r;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (rd_resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_resp_unexpected: got pulse data %05h, required none",
                   rd_resp_data);
        end else begin
          e = sb.pop_front();
          chk("rd_resp_data", 32'(rd_resp_data), 32'(e.data));
          chk("rd_resp_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a negedge with RSTN low; returns in the first RUN cycle.
  task automatic run_init();
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    RSTN = 1'b1;
    #1;
    chk("boot_pins", 32'({sram_ceb, sram_web, wr_ready, rd_ready, init_done}),
        32'(5'b11000));
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      #1;
      chk("init_cycle",
          32'({sram_ceb, sram_web, sram_a, sram_d, wr_ready, rd_ready, init_done}),
          32'({1'b0, 1'b0, 6'(i), 20'h0, 3'b000}));
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    @(negedge CLK);
    #1;
    chk("init_done", 32'(init_done), 32'd1);
    chk("run_idle_pins", 32'({sram_ceb, sram_web}), 32'(2'b11));
  endtask

  task automatic do_write(input logic [5:0] a, input logic [19:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    while (!wr_ready && n < 20) begin
      @(negedge CLK);
      #2;
      n++;
    end
    chk("wr_grant", 32'(wr_ready), 32'd1);
    @(negedge CLK);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [19:0] exp);
    int n = 0;
    rd_valid = 1'b1;
    rd_addr  = a;
    #1;
    while (!rd_ready && n < 20) begin
      @(negedge CLK);
      #2;
      n++;
    end
    chk("rd_grant", 32'(rd_ready), 32'd1);
    if (rd_ready) sb.push_back('{data: exp, cyc: cyc});
    @(negedge CLK);
    #1;
    rd_valid = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    #1;
    chk("reset_pins",
        32'({sram_ceb, sram_web, wr_ready, rd_ready, init_done, rd_resp_valid}),
        32'(6'b110000));
    chk("reset_resp_data", 32'(rd_resp_data), 32'h0);
    @(negedge CLK);
    run_init();

    do_read(6'd0, 20'h0);
    do_read(6'd31, 20'h0);
    do_read(6'd63, 20'h0);

    do_write(6'd5, 20'hABCDE);
    do_read(6'd5, 20'hABCDE);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      chk("idle_pins", 32'({sram_ceb, sram_web, rd_resp_valid}), 32'(3'b110));
      chk("hold_data", 32'(rd_resp_data), 32'hABCDE);
    end

    wr_valid = 1'b1;
    rd_valid = 1'b1;
    wr_addr  = 6'd3;
    rd_addr  = 6'd3;
    for (int c = 0; c < 6; c++) begin
      wr_data = 20'(c / 2 + 1);
      #1;
      chk("contention_grant", 32'({wr_ready, rd_ready}),
          (c % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
      if (c % 2 == 1) sb.push_back('{data: 20'(c / 2 + 1), cyc: cyc});
      @(negedge CLK);
      #1;
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;

    @(negedge CLK);
    #1;
    rd_valid = 1'b1;
    rd_addr  = 6'd5;
    #1;
    chk("midrst_grant", 32'(rd_ready), 32'd1);
    #1;
    RSTN = 1'b0;
    #1;
    chk("midrst_pins", 32'({rd_resp_valid, init_done, rd_ready, sram_ceb}),
        32'(4'b0001));
    chk("midrst_resp_data", 32'(rd_resp_data), 32'h0);
    rd_valid = 1'b0;
    @(negedge CLK);
    #1;
    chk("midrst_no_resp", 32'(rd_resp_valid), 32'd0);
    @(negedge CLK);
    run_init();

    do_read(6'd5, 20'h0);
    repeat (3) @(negedge CLK);
    #4;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s011hd1p_arbiter.md
# s011hd1p_arbiter

Access controller for one 64x20 single-port SRAM macro (active-low CEB/WEB, registered Q, Q undefined on non-read cycles). After reset it clears every word to zero. It then shares the single port between one write requester and one read requester using valid/ready handshakes with round-robin priority. Read data is returned one cycle after grant and held stable until the next read response, which hides the macro's undefined Q on idle and write cycles. It sits between cache/tag logic and the SRAM macro instance.

## Interface

- ADDR_W, 6, address width.
- DATA_W, 20, data width.
- DEPTH, 64, number of words (= 2^ADDR_W).

- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- init_done  out  1  high once the clear sequence has finished; stays high until the next reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write granted this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read granted this cycle.
- rd_addr  in  ADDR_W  read address.
- rd_resp_valid  out  1  one-cycle pulse; read data is valid.
- rd_resp_data  out  DATA_W  read data, held between responses.
- sram_ceb  out  1  macro chip enable, active low.
- sram_web  out  1  macro write enable, active low.
- sram_a  out  ADDR_W  macro address.
- sram_d  out  DATA_W  macro write data.
- sram_q  in  DATA_W  macro read data.

## Operation

- The FSM has three states: BOOT, INIT, RUN. Reset forces BOOT.
- **BOOT**: one cycle.
  - sram_ceb=1, sram_web=1, both readies 0.
  - Next state is INIT, with clr_cnt=0.
- **INIT**: writes zero to one address per cycle.
  - Drives sram_ceb=0, sram_web=0, sram_a=clr_cnt, sram_d=0.
  - clr_cnt increments every cycle.
  - On the cycle clr_cnt==DEPTH-1, the next state is RUN.
  - wr_ready=rd_ready=0 throughout; requests simply wait.
- **RUN**: arbitration.
  - Only wr_valid: wr_ready=1.
  - Only rd_valid: rd_ready=1.
  - Both valid: the requester indicated by prio gets ready, the other gets 0.
  - Neither valid: sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
- A handshake completes in the same cycle as ready=1 with valid=1.
- **Macro drive**: combinational from the grant, so the macro samples at the edge that ends the handshake cycle.
  - Write grant: ceb=0, web=0, a=wr_addr, d=wr_data.
  - Read grant: ceb=0, web=1, a=rd_addr, d=0.
- **Priority**: the prio register updates after every grant. A write grant sets prio=READ; a read grant sets prio=WRITE. Reset value is WRITE.
- **Read response**:
  - resp_pending is a register set on a read grant, otherwise cleared. It drives rd_resp_valid.
  - While rd_resp_valid=1, rd_resp_data=sram_q, and hold_q captures sram_q.
  - Otherwise rd_resp_data=hold_q.
- **Same-address write and read in one cycle**: only one is granted. The order follows prio, so a read issued after a write returns the new data.
- There is no backpressure on responses; the consumer must accept the rd_resp_valid pulse.

## Timing

- **Reset values**: state=BOOT, clr_cnt=0, init_done=0, rd_resp_valid=0, hold_q=0 (so rd_resp_data=0), prio=WRITE, wr_ready=rd_ready=0, sram_ceb=1, sram_web=1.
- **Init duration**: RSTN rises before edge 0. BOOT is cycle 0, INIT spans cycles 1..64, and RUN starts at cycle 65. init_done goes high in cycle 65 (registered).
- **Read latency**: grant in cycle N, rd_resp_valid=1 in cycle N+1 with data. Back-to-back reads give one response per cycle.
- **Write**: takes effect at the end of the grant cycle. A read granted in the following cycle sees the written data.
- **Throughput**: one access per cycle in RUN. With both requesters continuously valid, grants alternate W,R,W,R starting with W after init.
- **Reset mid-operation**:
  - Asynchronous return to BOOT.
  - rd_resp_valid and init_done drop immediately, and any pending response is discarded.
  - hold_q returns to 0.
  - The clear sequence reruns in full.
- **Reset during INIT**: restarts at clr_cnt=0.

## Test plan

- **Reset/init**: release RSTN; check BOOT for 1 cycle, 64 consecutive writes to addresses 0..63 with D=0, and init_done=1 at cycle 65. Requests held valid during INIT receive ready=0 throughout.
- **Write/read**: write addr 5 = 0xABCDE; read addr 5 in the next cycle. Expect rd_resp_valid one cycle after rd_ready and data 0xABCDE. rd_resp_data stays 0xABCDE over the following 10 idle cycles.
- **Contention**: hold both valid for 6 cycles (write addr 3 data i, read addr 3). Expect grant order W,R,W,R,W,R. Each read returns the immediately preceding write's data.
- **Cleared contents**: after init, read addresses 0, 31, 63 → each returns 0x00000.
- **Reset mid-operation**: assert RSTN low in the same cycle as a read grant. Expect no rd_resp_valid, rd_resp_data=0, init_done=0, and the full 64-cycle clear rerun. A subsequent read of an earlier-written address returns 0.
- **Idle**: no requests in RUN → sram_ceb=1, sram_web=1, and no rd_resp_valid pulses.
